// File: rtl/fmap_pool_streamer_pkg.sv
// Shared CNN definitions: feature-map geometry defaults, pooling FSM state
// encoding and the feature-map RAM address helper.
package fmap_pool_streamer_pkg;

    localparam int CNN_DATA_W  = 32;
    localparam int CNN_FMAP_W  = 6;
    localparam int CNN_FMAP_H  = 6;
    localparam int FMAP_ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4
    } pool_state_t;

    // Row-major word address of (row, col) in a feature map fmap_w columns wide.
    function automatic logic [FMAP_ADDR_W-1:0] fmap_addr(input int row, input int col,
                                                         input int fmap_w);
        return FMAP_ADDR_W'(row * fmap_w + col);
    endfunction

endpackage

// File: rtl/fmap_pool_streamer_max_cmp.sv
// Signed comparator returning the larger operand; on a tie the held operand
// wins so the running maximum only moves on a strict improvement.
module max_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] held,
    input  logic [DATA_W-1:0] cand,
    output logic [DATA_W-1:0] larger
);

    // Strict signed greater-than keeps ties on the held value.
    assign larger = ($signed(cand) > $signed(held)) ? cand : held;

endmodule

// File: rtl/fmap_pool_streamer.sv
// 2x2 stride-2 max-pooling streamer: reads each window from the feature-map
// RAM, reduces it to its signed maximum and hands it out on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | issuing the four reads of the current window
// DRAIN  | waiting for the last read words to be captured
// EMIT   | pooled word presented, waiting for out_ready
// FINISH | one-cycle done pulse, then back to IDLE
module fmap_pool_streamer
    import fmap_pool_streamer_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int FMAP_W = CNN_FMAP_W,
    parameter int FMAP_H = CNN_FMAP_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [5:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int WIN_COLS = FMAP_W / 2;
    localparam int WIN_ROWS = FMAP_H / 2;
    localparam logic [FMAP_ADDR_W-1:0] LAST_C = FMAP_ADDR_W'(WIN_COLS - 1);
    localparam logic [FMAP_ADDR_W-1:0] LAST_R = FMAP_ADDR_W'(WIN_ROWS - 1);

    pool_state_t             state;
    logic [FMAP_ADDR_W-1:0]  win_r, win_c;
    logic [FMAP_ADDR_W-1:0]  nxt_r, nxt_c;
    logic                    last_win;
    logic [1:0]              rd_idx;
    logic [1:0]              cap_cnt;
    logic                    rd_pend;
    logic [DATA_W-1:0]       run_max;
    logic [DATA_W-1:0]       max_y;

    max_cmp #(.DATA_W(DATA_W)) u_max_cmp (
        .held   (run_max),
        .cand   (rd_data),
        .larger (max_y)
    );

    // Next window position in row-major order and last-window detect.
    always_comb begin
        last_win = (win_r == LAST_R) && (win_c == LAST_C);
        nxt_r    = win_r;
        nxt_c    = win_c + FMAP_ADDR_W'(1);
        if (win_c == LAST_C) begin
            nxt_c = '0;
            nxt_r = win_r + FMAP_ADDR_W'(1);
        end
    end

    // Sequencer, read-data capture pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            win_r     <= '0;
            win_c     <= '0;
            rd_idx    <= '0;
            cap_cnt   <= '0;
            rd_pend   <= 1'b0;
            run_max   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // rd_data lags rd_en by one cycle, so capture one cycle behind the strobe.
            rd_pend <= rd_en;
            done    <= 1'b0;
            if (rd_pend) begin
                cap_cnt <= cap_cnt + 2'd1;
                run_max <= (cap_cnt == 2'd0) ? rd_data : max_y;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_READ;
                        busy    <= 1'b1;
                        win_r   <= '0;
                        win_c   <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= fmap_addr(0, 0, FMAP_W);
                        rd_idx  <= 2'd1;
                    end
                end
                ST_READ: begin
                    rd_addr <= fmap_addr(2 * int'(win_r) + int'(rd_idx[1]),
                                         2 * int'(win_c) + int'(rd_idx[0]), FMAP_W);
                    rd_idx  <= rd_idx + 2'd1;
                    if (rd_idx == 2'd3) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    rd_en <= 1'b0;
                    if (rd_pend && cap_cnt == 2'd3) begin
                        state     <= ST_EMIT;
                        out_valid <= 1'b1;
                        out_data  <= max_y;
                        out_last  <= last_win;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (last_win) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_READ;
                            win_r   <= nxt_r;
                            win_c   <= nxt_c;
                            rd_en   <= 1'b1;
                            rd_addr <= fmap_addr(2 * int'(nxt_r), 2 * int'(nxt_c), FMAP_W);
                            rd_idx  <= 2'd1;
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_pool_streamer.sv
// Self-checking bench for fmap_pool_streamer: feature-map RAM model plus a
// queue of expected pooled words built from the RAM contents at each start.
module tb_fmap_pool_streamer;

    localparam int DW = 32;
    localparam int FW = 6;
    localparam int FH = 6;

    typedef struct {
        logic signed [DW-1:0] d;
        logic                 last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic          rd_en, out_valid, out_last, busy, done;
    logic [5:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;

    logic signed [DW-1:0] mem [0:63];
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    fmap_pool_streamer #(.DATA_W(DW), .FMAP_W(FW), .FMAP_H(FH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: word appears one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) mem[i] = i;
    endtask

    // Reference pooling over the current RAM contents, pushed in emit order.
    task automatic push_expected();
        exp_t e;
        for (int r = 0; r < FH / 2; r++) begin
            for (int c = 0; c < FW / 2; c++) begin
                e.d = mem[(2 * r) * FW + 2 * c];
                for (int k = 1; k < 4; k++) begin
                    if (mem[(2 * r + k / 2) * FW + 2 * c + k % 2] > e.d)
                        e.d = mem[(2 * r + k / 2) * FW + 2 * c + k % 2];
                end
                e.last = (r == FH / 2 - 1) && (c == FW / 2 - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives out_ready and pops/compares every handshake until limit_hs
    // handshakes have occurred or the final word and done pulse are seen.
    task automatic consume(input int limit_hs, input int stall_win, input int stall_len,
                           input bit rand_ready, input bit poke_fin, output int hs);
        int   stall_left;
        int   cyc;
        bit   fin;
        exp_t e;
        hs = 0;
        stall_left = stall_len;
        cyc = 0;
        fin = 1'b0;
        while (cyc < 2000) begin
            if (stall_win >= 0 && hs == stall_win && out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (fin) begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_err++;
                    $display("FAIL done_pulse: got %0b, expected 1", done);
                end
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL no_extra_word: out_valid got %0b, expected 0", out_valid);
                end
                tick();
                start = 1'b0;
                break;
            end
            if (out_valid && !out_ready && exp_q.size() > 0) begin
                n_cmp++;
                if ($signed(out_data) !== exp_q[0].d) begin
                    n_err++;
                    $display("FAIL hold_data: got %0d, expected %0d", $signed(out_data), exp_q[0].d);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_word: got data %0d, expected no word", $signed(out_data));
                end else begin
                    e = exp_q.pop_front();
                    if ($signed(out_data) !== e.d || out_last !== e.last) begin
                        n_err++;
                        $display("FAIL out_word %0d: got %0d last %0b, expected %0d last %0b",
                                 hs, $signed(out_data), out_last, e.d, e.last);
                    end
                    if (e.last) fin = 1'b1;
                end
                hs++;
            end
            tick();
            cyc++;
            if (fin && poke_fin) start = 1'b1;
            if (!fin && hs == limit_hs) break;
        end
        if (cyc >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL consume_timeout: got %0d handshakes, expected %0d", hs, limit_hs);
        end
        if (fin) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL back_to_idle: got done %0b busy %0b, expected 0 0", done, busy);
            end
            tick();
        end
    endtask

    task automatic check_pass_total(input string name, input int hs);
        n_cmp++;
        if (hs != 9 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: got %0d handshakes (%0d left), expected 9 (0 left)",
                     name, hs, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rd_en, rd_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got en %0b addr %0d ov %0b od %0d ol %0b busy %0b done %0b, expected all 0",
                     rd_en, rd_addr, out_valid, out_data, out_last, busy, done);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_start_timing();
        int addr_tab [4];
        int hs;
        addr_tab = '{0, 1, 6, 7};
        fill_ramp();
        exp_q.delete();
        push_expected();
        out_ready = 1'b0;
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_en !== (i <= 4)) begin
                n_err++;
                $display("FAIL rd_en_t+%0d: got %0b, expected %0b", i, rd_en, (i <= 4));
            end
            n_cmp++;
            if (rd_addr !== 6'(addr_tab[(i <= 4) ? i - 1 : 3])) begin
                n_err++;
                $display("FAIL rd_addr_t+%0d: got %0d, expected %0d", i, rd_addr,
                         addr_tab[(i <= 4) ? i - 1 : 3]);
            end
            n_cmp++;
            if (out_valid !== (i == 6)) begin
                n_err++;
                $display("FAIL out_valid_t+%0d: got %0b, expected %0b", i, out_valid, (i == 6));
            end
        end
        tick();
        consume(9, -1, 0, 1'b0, 1'b0, hs);
        check_pass_total("timing_pass", hs);
    endtask

    task automatic test_ramp_ready_high();
        int hs;
        fill_ramp();
        exp_q.delete();
        push_expected();
        out_ready = 1'b1;
        pulse_start();
        consume(9, -1, 0, 1'b0, 1'b0, hs);
        check_pass_total("ramp_pass", hs);
    endtask

    task automatic test_negative_window();
        int hs;
        fill_ramp();
        mem[0] = -5;
        mem[1] = -2;
        mem[6] = -9;
        mem[7] = -3;
        exp_q.delete();
        push_expected();
        n_cmp++;
        if (exp_q[0].d !== -2) begin
            n_err++;
            $display("FAIL neg_model: got %0d, expected -2", exp_q[0].d);
        end
        pulse_start();
        consume(9, -1, 0, 1'b0, 1'b0, hs);
        check_pass_total("neg_pass", hs);
    endtask

    task automatic test_backpressure();
        int hs;
        fill_ramp();
        exp_q.delete();
        push_expected();
        out_ready = 1'b1;
        pulse_start();
        consume(9, 4, 10, 1'b0, 1'b0, hs);
        check_pass_total("backpressure_pass", hs);
    endtask

    task automatic test_start_while_busy();
        int hs;
        int stray;
        fill_ramp();
        exp_q.delete();
        push_expected();
        out_ready = 1'b1;
        pulse_start();
        tick();
        pulse_start();
        consume(9, -1, 0, 1'b0, 1'b1, hs);
        check_pass_total("busy_start_pass", hs);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_en || busy) stray++;
            tick();
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL finish_start_ignored: got %0d active cycles, expected 0", stray);
        end
    endtask

    task automatic test_mid_reset();
        int hs;
        fill_ramp();
        exp_q.delete();
        push_expected();
        out_ready = 1'b1;
        pulse_start();
        consume(3, -1, 0, 1'b0, 1'b0, hs);
        tick();
        n_cmp++;
        if (rd_en !== 1'b1) begin
            n_err++;
            $display("FAIL win3_reading: got rd_en %0b, expected 1", rd_en);
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rd_en, rd_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got en %0b addr %0d ov %0b od %0d busy %0b, expected all 0",
                     rd_en, rd_addr, out_valid, out_data, busy);
        end
        rst = 1'b0;
        tick();
        exp_q.delete();
        push_expected();
        n_cmp++;
        if (exp_q[0].d !== 7) begin
            n_err++;
            $display("FAIL restart_model: got %0d, expected 7", exp_q[0].d);
        end
        pulse_start();
        consume(9, -1, 0, 1'b0, 1'b0, hs);
        check_pass_total("restart_pass", hs);
    endtask

    task automatic test_random();
        int hs;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 64; i++) mem[i] = $signed($urandom_range(0, 20)) - 10;
            exp_q.delete();
            push_expected();
            pulse_start();
            consume(9, -1, 0, 1'b1, 1'b0, hs);
            check_pass_total("random_pass", hs);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        fill_ramp();
        test_reset();
        test_start_timing();
        test_ramp_ready_high();
        test_negative_window();
        test_backpressure();
        test_start_while_busy();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
